rtc_bus_arbiter: RTL and testbench

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_pkg.sv | 53 +++++
 rtl/rr_arbiter3.sv | 55 +++++
 rtl/rtc_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter: phase states, requester
// indices and the active-low strobe encodings driven in each bus phase.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP  = 3'd2,
        ST_DATA = 3'd3,
        ST_REC  = 3'd4
    } state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_READER   = 2'd0;
    localparam logic [1:0] REQ_DATETIME = 2'd1;
    localparam logic [1:0] REQ_TIMER    = 2'd2;

    typedef struct packed {
        logic cs_n;
        logic ad_n;
        logic rd_n;
        logic wr_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = 4'b1111;
    localparam strobes_t STROBES_ADDR = 4'b0011;
    localparam strobes_t STROBES_GAP  = 4'b0111;
    localparam strobes_t STROBES_RD   = 4'b0101;
    localparam strobes_t STROBES_WR   = 4'b0110;

    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = REQ_DATETIME;
            3'b100:  idx = REQ_TIMER;
            default: idx = REQ_READER;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            REQ_READER:   oh = 3'b001;
            REQ_DATETIME: oh = 3'b010;
            REQ_TIMER:    oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin selector: the search starts at the requester after
// the last winner and wraps around.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] win,
    output logic       valid
);
    import rtc_bus_pkg::*;

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // search order derived from the previous winner
    always_comb begin
        first_s  = REQ_READER;
        second_s = REQ_DATETIME;
        third_s  = REQ_TIMER;
        case (last)
            REQ_READER: begin
                first_s  = REQ_DATETIME;
                second_s = REQ_TIMER;
                third_s  = REQ_READER;
            end
            REQ_DATETIME: begin
                first_s  = REQ_TIMER;
                second_s = REQ_READER;
                third_s  = REQ_DATETIME;
            end
            default: begin
                first_s  = REQ_READER;
                second_s = REQ_DATETIME;
                third_s  = REQ_TIMER;
            end
        endcase
    end

    // first requesting index in search order wins
    always_comb begin
        win = 3'b000;
        if ((req & idx_to_onehot(first_s)) != 3'b000) begin
            win = idx_to_onehot(first_s);
        end else if ((req & idx_to_onehot(second_s)) != 3'b000) begin
            win = idx_to_onehot(second_s);
        end else if ((req & idx_to_onehot(third_s)) != 3'b000) begin
            win = idx_to_onehot(third_s);
        end else begin
            win = 3'b000;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates three requesters onto a multiplexed RTC bus and sequences each
// transaction through address, gap, data and recovery phases.
module rtc_bus_arbiter #(
    parameter int T_ADDR = 4,
    parameter int T_GAP  = 2,
    parameter int T_DATA = 6,
    parameter int T_REC  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] we,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);
    import rtc_bus_pkg::*;

    localparam logic [3:0] T_ADDR_M1 = 4'(T_ADDR - 1);
    localparam logic [3:0] T_GAP_M1  = 4'(T_GAP - 1);
    localparam logic [3:0] T_DATA_M1 = 4'(T_DATA - 1);
    localparam logic [3:0] T_REC_M1  = 4'(T_REC - 1);

    state_t               state_r, next_state_s;
    logic [3:0]           cnt_r, next_cnt_s;
    logic [1:0]           last_r;
    logic                 we_r;
    logic [7:0]           addr_r, wdata_r, rdata_r;
    logic [NUM_REQ-1:0]   win_s;
    logic                 win_valid_s, grant_s;
    logic [1:0]           win_idx_s;
    logic                 win_we_s, nxt_we_s;
    logic [7:0]           win_addr_s, win_wdata_s, nxt_addr_s, nxt_wdata_s;
    strobes_t             nxt_strb_s, strb_r;
    logic                 nxt_oe_s, oe_r;
    logic [7:0]           nxt_out_s, out_r;
    logic [NUM_REQ-1:0]   nxt_gnt_s, nxt_done_s, gnt_r, done_r;
    logic                 busy_r;

    rr_arbiter3 u_rr (
        .req   (req),
        .last  (last_r),
        .win   (win_s),
        .valid (win_valid_s)
    );

    // request fields of the current winner
    always_comb begin
        win_idx_s = onehot3_to_idx(win_s);
        case (win_idx_s)
            REQ_READER: begin
                win_we_s    = we[0];
                win_addr_s  = addr0;
                win_wdata_s = wdata0;
            end
            REQ_DATETIME: begin
                win_we_s    = we[1];
                win_addr_s  = addr1;
                win_wdata_s = wdata1;
            end
            REQ_TIMER: begin
                win_we_s    = we[2];
                win_addr_s  = addr2;
                win_wdata_s = wdata2;
            end
            default: begin
                win_we_s    = we[0];
                win_addr_s  = addr0;
                win_wdata_s = wdata0;
            end
        endcase
    end

    // phase sequencing: each phase counts down from its length minus one
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        grant_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    next_state_s = ST_ADDR;
                    next_cnt_s   = T_ADDR_M1;
                    grant_s      = 1'b1;
                end else begin
                    next_cnt_s   = 4'd0;
                end
            end
            ST_ADDR: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_GAP;
                    next_cnt_s   = T_GAP_M1;
                end else begin
                    next_cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_DATA;
                    next_cnt_s   = T_DATA_M1;
                end else begin
                    next_cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_REC;
                    next_cnt_s   = T_REC_M1;
                end else begin
                    next_cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_REC: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end else begin
                    next_cnt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // transaction fields as they will be after this edge
    always_comb begin
        if (grant_s) begin
            nxt_we_s    = win_we_s;
            nxt_addr_s  = win_addr_s;
            nxt_wdata_s = win_wdata_s;
        end else begin
            nxt_we_s    = we_r;
            nxt_addr_s  = addr_r;
            nxt_wdata_s = wdata_r;
        end
    end

    // bus drive for the upcoming phase, so pins change together with the state
    always_comb begin
        nxt_strb_s = STROBES_IDLE;
        nxt_oe_s   = 1'b0;
        nxt_out_s  = 8'h00;
        case (next_state_s)
            ST_ADDR: begin
                nxt_strb_s = STROBES_ADDR;
                nxt_oe_s   = 1'b1;
                nxt_out_s  = nxt_addr_s;
            end
            ST_GAP: begin
                nxt_strb_s = STROBES_GAP;
                nxt_oe_s   = nxt_we_s;
                nxt_out_s  = nxt_we_s ? nxt_wdata_s : 8'h00;
            end
            ST_DATA: begin
                nxt_strb_s = nxt_we_s ? STROBES_WR : STROBES_RD;
                nxt_oe_s   = nxt_we_s;
                nxt_out_s  = nxt_we_s ? nxt_wdata_s : 8'h00;
            end
            default: begin
                nxt_strb_s = STROBES_IDLE;
                nxt_oe_s   = 1'b0;
                nxt_out_s  = 8'h00;
            end
        endcase
        nxt_gnt_s  = grant_s ? win_s : 3'b000;
        nxt_done_s = ((state_r == ST_DATA) && (next_state_s == ST_REC)) ?
                     idx_to_onehot(last_r) : 3'b000;
    end

    // state, counter and latched transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            last_r  <= REQ_TIMER;
            we_r    <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            we_r    <= nxt_we_s;
            addr_r  <= nxt_addr_s;
            wdata_r <= nxt_wdata_s;
            if (grant_s) begin
                last_r <= win_idx_s;
            end
        end
    end

    // registered bus pins and handshake pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strb_r <= STROBES_IDLE;
            oe_r   <= 1'b0;
            out_r  <= 8'h00;
            gnt_r  <= 3'b000;
            done_r <= 3'b000;
            busy_r <= 1'b0;
        end else begin
            strb_r <= nxt_strb_s;
            oe_r   <= nxt_oe_s;
            out_r  <= nxt_out_s;
            gnt_r  <= nxt_gnt_s;
            done_r <= nxt_done_s;
            busy_r <= (next_state_s != ST_IDLE);
        end
    end

    // read data sampled at the close of the read strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 8'h00;
        end else if ((state_r == ST_DATA) && (cnt_r == 4'd0) && !we_r) begin
            rdata_r <= ad_in;
        end
    end

    assign gnt    = gnt_r;
    assign done   = done_r;
    assign rdata  = rdata_r;
    assign busy   = busy_r;
    assign cs_n   = strb_r.cs_n;
    assign ad_n   = strb_r.ad_n;
    assign rd_n   = strb_r.rd_n;
    assign wr_n   = strb_r.wr_n;
    assign ad_oe  = oe_r;
    assign ad_out = out_r;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: default timing and all-ones timing instances share
// one stimulus stream; a transaction-level model feeds per-instance scoreboards.
module tb_rtc_bus_arbiter;

    typedef struct {
        int         cyc;
        logic [1:0] who;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] we = 3'b000;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, addr2 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00, wdata2 = 8'h00;
    logic [7:0] ad_in = 8'h00;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %0h, expected %0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pick8(input int c, input logic [7:0] a0,
                                         input logic [7:0] a1, input logic [7:0] a2);
        return (c == 0) ? a0 : ((c == 1) ? a1 : a2);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int TA = (gi == 0) ? 4 : 1;
        localparam int TG = (gi == 0) ? 2 : 1;
        localparam int TD = (gi == 0) ? 6 : 1;
        localparam int TR = (gi == 0) ? 8 : 1;
        localparam int P  = TA + TG + TD + TR;

        logic [2:0] gnt, done;
        logic [7:0] rdata, ad_out;
        logic       busy, cs_n, ad_n, rd_n, wr_n, ad_oe;
        txn_t       gq[$];
        rd_t        rq[$];

        rtc_bus_arbiter #(.T_ADDR(TA), .T_GAP(TG), .T_DATA(TD), .T_REC(TR)) dut (
            .clk(clk), .reset(reset), .req(req), .we(we),
            .addr0(addr0), .addr1(addr1), .addr2(addr2),
            .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
            .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
            .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
            .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
        );

        // reference model: decides grants and read captures per clock edge
        initial begin : model
            int last;
            int free_edge;
            int cur_g;
            bit cur_rd;
            int e;
            int c;
            last = 2; free_edge = 0; cur_g = -1000; cur_rd = 1'b0;
            forever begin
                @(posedge clk);
                #3;
                if (reset == 1'b0) begin
                    gq.delete(); rq.delete();
                    last = 2; free_edge = 0; cur_g = -1000; cur_rd = 1'b0;
                end else begin
                    e = cyc + 1;
                    if (cur_rd && (e == cur_g + TA + TG + TD))
                        rq.push_back('{e, ad_in});
                    if ((e >= free_edge) && (req != 3'b000)) begin
                        for (int i = 1; i <= 3; i++) begin
                            c = (last + i) % 3;
                            if (req[c]) begin
                                gq.push_back('{e, 2'(c), we[c],
                                    pick8(c, addr0, addr1, addr2),
                                    pick8(c, wdata0, wdata1, wdata2)});
                                last = c; free_edge = e + P + 1;
                                cur_g = e; cur_rd = !we[c];
                                break;
                            end
                        end
                    end
                end
            end
        end

        // monitor: compares every cycle against the expected transaction
        initial begin : monitor
            txn_t        cur;
            rd_t         r;
            bit          active;
            logic [7:0]  exp_rdata;
            logic [2:0]  eg, ed;
            logic [12:0] eb;
            logic        ebusy;
            int          o;
            active = 1'b0; exp_rdata = 8'h00;
            forever begin
                @(negedge clk);
                if (reset == 1'b0) begin
                    active = 1'b0; exp_rdata = 8'h00;
                    check("rst_gnt", gi, 32'(gnt), 32'h0);
                    check("rst_done", gi, 32'(done), 32'h0);
                    check("rst_busy", gi, 32'(busy), 32'h0);
                    check("rst_rdata", gi, 32'(rdata), 32'h0);
                    check("rst_bus", gi, 32'({cs_n, ad_n, rd_n, wr_n, ad_oe, ad_out}),
                          32'({4'b1111, 1'b0, 8'h00}));
                end else begin
                    while ((gq.size() > 0) && (gq[0].cyc < cyc)) void'(gq.pop_front());
                    eg = 3'b000;
                    if ((gq.size() > 0) && (gq[0].cyc == cyc)) begin
                        cur = gq.pop_front();
                        active = 1'b1;
                        eg = 3'b001 << cur.who;
                    end
                    check("gnt", gi, 32'(gnt), 32'(eg));
                    while ((rq.size() > 0) && (rq[0].cyc <= cyc)) begin
                        r = rq.pop_front();
                        exp_rdata = r.val;
                    end
                    check("rdata", gi, 32'(rdata), 32'(exp_rdata));
                    eb = {4'b1111, 1'b0, 8'h00}; ed = 3'b000; ebusy = 1'b0;
                    if (active) begin
                        o = cyc - cur.cyc;
                        if (o >= P) begin
                            active = 1'b0;
                        end else begin
                            ebusy = 1'b1;
                            if (o < TA)
                                eb = {4'b0011, 1'b1, cur.addr};
                            else if (o < TA + TG)
                                eb = {4'b0111, cur.we, cur.we ? cur.wdata : 8'h00};
                            else if (o < TA + TG + TD)
                                eb = {2'b01, cur.we, !cur.we, cur.we, cur.we ? cur.wdata : 8'h00};
                            else if (o == TA + TG + TD)
                                ed = 3'b001 << cur.who;
                        end
                    end
                    check("bus", gi, 32'({cs_n, ad_n, rd_n, wr_n, ad_oe, ad_out}), 32'(eb));
                    check("done", gi, 32'(done), 32'(ed));
                    check("busy", gi, 32'(busy), 32'(ebusy));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : stim
        #1 reset = 1'b0;
        step(3);
        // read from requester 0
        reset = 1'b1; req = 3'b001; we = 3'b000; addr0 = 8'h21; ad_in = 8'h59;
        step(1); req = 3'b000; step(24);
        // write from requester 1
        req = 3'b010; we = 3'b010; addr1 = 8'h24; wdata1 = 8'h07; ad_in = 8'hA5;
        step(1); req = 3'b000; step(24);
        // full contention from reset release
        reset = 1'b0; step(2);
        reset = 1'b1; req = 3'b111; we = 3'b101;
        step(100); req = 3'b000; step(25);
        // reset during a write strobe, then contention
        req = 3'b010; we = 3'b010; wdata1 = 8'h3C;
        step(1); req = 3'b000; step(8);
        reset = 1'b0; step(2);
        reset = 1'b1; req = 3'b111; step(3); req = 3'b000; step(25);
        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            we = 3'($urandom);
            addr0 = 8'($urandom); addr1 = 8'($urandom); addr2 = 8'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
            ad_in = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        reset = 1'b1; req = 3'b000;
        step(25);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
